// File: rtl/up_dn_counter_range.sv
// Up/down counter that stays inside a programmable window [Lim_Lo, Lim_Hi].
// Moves by a programmable step and either saturates or wraps at the limits.
module up_dn_counter_range #(
  parameter int               WIDTH   = 5,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] IN,
  input  logic             Load,
  input  logic             Up,
  input  logic             Down,
  input  logic [WIDTH-1:0] Step,
  input  logic [WIDTH-1:0] Lim_Lo,
  input  logic [WIDTH-1:0] Lim_Hi,
  input  logic             Mode,
  output logic [WIDTH-1:0] Counter,
  output logic             High,
  output logic             Low,
  output logic             Wrap_Pulse,
  output logic             Sat_Pulse,
  output logic             Cfg_Err
);

  logic [WIDTH:0]   span;
  logic [WIDTH-1:0] diff_lo;
  logic [WIDTH-1:0] diff_hi;
  logic [WIDTH-1:0] dn_wrap;
  logic [WIDTH-1:0] up_wrap;
  logic [WIDTH-1:0] cnt_nxt;
  logic             wrap_nxt;
  logic             sat_nxt;

  // Span needs WIDTH+1 bits: a full-range window holds 2^WIDTH values.
  assign span    = {1'b0, Lim_Hi} - {1'b0, Lim_Lo} + {{WIDTH{1'b0}}, 1'b1};
  assign Cfg_Err = (Lim_Lo > Lim_Hi) || ({1'b0, Step} > span);
  assign High    = (Counter == Lim_Hi);
  assign Low     = (Counter == Lim_Lo);

  // Headroom to each limit; only used when Counter is inside the window.
  assign diff_lo = Counter - Lim_Lo;
  assign diff_hi = Lim_Hi - Counter;

  // A wrapped result always lies inside the window, so it fits in WIDTH bits
  // and the modulo-2^WIDTH intermediate arithmetic gives the exact value.
  assign dn_wrap = Counter - Step + span[WIDTH-1:0];
  assign up_wrap = Counter + Step - span[WIDTH-1:0];

  always_comb begin
    cnt_nxt  = Counter;
    wrap_nxt = 1'b0;
    sat_nxt  = 1'b0;
    if (!Cfg_Err) begin
      if (Load) begin
        if (IN < Lim_Lo) begin
          cnt_nxt = Lim_Lo;
          sat_nxt = 1'b1;
        end else if (IN > Lim_Hi) begin
          cnt_nxt = Lim_Hi;
          sat_nxt = 1'b1;
        end else begin
          cnt_nxt = IN;
        end
      end else if (Counter < Lim_Lo) begin
        cnt_nxt = Lim_Lo;
        sat_nxt = 1'b1;
      end else if (Counter > Lim_Hi) begin
        cnt_nxt = Lim_Hi;
        sat_nxt = 1'b1;
      end else if (Down) begin
        if (Step <= diff_lo) begin
          cnt_nxt = Counter - Step;
        end else if (!Mode) begin
          // Already at the floor: hold quietly instead of re-clamping.
          if (!Low) begin
            cnt_nxt = Lim_Lo;
            sat_nxt = 1'b1;
          end
        end else begin
          cnt_nxt  = dn_wrap;
          wrap_nxt = 1'b1;
        end
      end else if (Up) begin
        if (Step <= diff_hi) begin
          cnt_nxt = Counter + Step;
        end else if (!Mode) begin
          if (!High) begin
            cnt_nxt = Lim_Hi;
            sat_nxt = 1'b1;
          end
        end else begin
          cnt_nxt  = up_wrap;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Counter    <= RST_VAL;
      Wrap_Pulse <= 1'b0;
      Sat_Pulse  <= 1'b0;
    end else begin
      Counter    <= cnt_nxt;
      Wrap_Pulse <= wrap_nxt;
      Sat_Pulse  <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_up_dn_counter_range.sv
// Directed bench for up_dn_counter_range (WIDTH=5, RST_VAL=0).
module tb_up_dn_counter_range;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] IN;
  logic       Load, Up, Down, Mode;
  logic [4:0] Step, Lim_Lo, Lim_Hi;
  logic [4:0] Counter;
  logic       High, Low, Wrap_Pulse, Sat_Pulse, Cfg_Err;

  int n_checks = 0;
  int n_fail   = 0;

  up_dn_counter_range #(.WIDTH(5), .RST_VAL(5'd0)) dut (
    .clk(clk), .rst_n(rst_n), .IN(IN), .Load(Load), .Up(Up), .Down(Down),
    .Step(Step), .Lim_Lo(Lim_Lo), .Lim_Hi(Lim_Hi), .Mode(Mode),
    .Counter(Counter), .High(High), .Low(Low), .Wrap_Pulse(Wrap_Pulse),
    .Sat_Pulse(Sat_Pulse), .Cfg_Err(Cfg_Err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; IN = '0; Load = 0; Up = 0; Down = 0; Mode = 0;
    Step = 5'd1; Lim_Lo = 5'd0; Lim_Hi = 5'd31;
    #1;
    n_checks++;
    if (Counter !== 5'd0 || Wrap_Pulse !== 1'b0 || Sat_Pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: Counter=%0d wrap=%b sat=%b expected 0/0/0", Counter, Wrap_Pulse, Sat_Pulse);
    end
    n_checks++;
    if (Cfg_Err !== 1'b0 || Low !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_flags: Cfg_Err=%b Low=%b expected 0/1", Cfg_Err, Low);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_up_saturate();
    logic [4:0] exp;
    Up = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      exp = (i + 1 > 31) ? 5'd31 : 5'(i + 1);
      n_checks++;
      if (Counter !== exp || Sat_Pulse !== 1'b0 || Wrap_Pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL up_sat[%0d]: Counter=%0d sat=%b wrap=%b expected %0d/0/0", i, Counter, Sat_Pulse, Wrap_Pulse, exp);
      end
    end
    n_checks++;
    if (High !== 1'b1) begin
      n_fail++;
      $display("FAIL up_sat_high: High=%b expected 1", High);
    end
    Up = 0;
  endtask

  task automatic test_wrap();
    Lim_Lo = 5'd4; Lim_Hi = 5'd10; Mode = 1; Step = 5'd3;
    IN = 5'd9; Load = 1;
    tick();
    Load = 0;
    n_checks++;
    if (Counter !== 5'd9 || Sat_Pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_load: Counter=%0d sat=%b expected 9/0", Counter, Sat_Pulse);
    end
    Up = 1;
    tick();
    n_checks++;
    if (Counter !== 5'd5 || Wrap_Pulse !== 1'b1 || Sat_Pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_up: Counter=%0d wrap=%b sat=%b expected 5/1/0", Counter, Wrap_Pulse, Sat_Pulse);
    end
    tick();
    n_checks++;
    if (Counter !== 5'd8 || Wrap_Pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_next: Counter=%0d wrap=%b expected 8/0", Counter, Wrap_Pulse);
    end
    Up = 0; IN = 5'd4; Load = 1;
    tick();
    Load = 0; Down = 1;
    tick();
    Down = 0;
    n_checks++;
    if (Counter !== 5'd8 || Wrap_Pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_down_low: Counter=%0d wrap=%b expected 8/1", Counter, Wrap_Pulse);
    end
  endtask

  task automatic test_down_saturate();
    Mode = 0; IN = 5'd6; Load = 1;
    tick();
    Load = 0; Step = 5'd4; Down = 1;
    tick();
    n_checks++;
    if (Counter !== 5'd4 || Sat_Pulse !== 1'b1 || Wrap_Pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL down_sat: Counter=%0d sat=%b wrap=%b expected 4/1/0", Counter, Sat_Pulse, Wrap_Pulse);
    end
    tick();
    Down = 0;
    n_checks++;
    if (Counter !== 5'd4 || Low !== 1'b1 || Sat_Pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL down_hold: Counter=%0d Low=%b sat=%b expected 4/1/0", Counter, Low, Sat_Pulse);
    end
  endtask

  task automatic test_load_clamp();
    IN = 5'd20; Load = 1;
    tick();
    Load = 0;
    n_checks++;
    if (Counter !== 5'd10 || Sat_Pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL load_clamp: Counter=%0d sat=%b expected 10/1", Counter, Sat_Pulse);
    end
    Lim_Hi = 5'd7;
    tick();
    n_checks++;
    if (Counter !== 5'd7 || Sat_Pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL limit_shrink: Counter=%0d sat=%b expected 7/1", Counter, Sat_Pulse);
    end
    tick();
    n_checks++;
    if (Counter !== 5'd7 || Sat_Pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL limit_settled: Counter=%0d sat=%b expected 7/0", Counter, Sat_Pulse);
    end
  endtask

  task automatic test_cfg_err();
    Lim_Lo = 5'd12; Lim_Hi = 5'd3;
    #1;
    n_checks++;
    if (Cfg_Err !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_inverted: Cfg_Err=%b expected 1", Cfg_Err);
    end
    IN = 5'd5; Load = 1; Up = 1; Down = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (Counter !== 5'd7 || Sat_Pulse !== 1'b0 || Wrap_Pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL cfg_frozen[%0d]: Counter=%0d sat=%b wrap=%b expected 7/0/0", i, Counter, Sat_Pulse, Wrap_Pulse);
      end
    end
    Load = 0; Down = 0;
    Lim_Lo = 5'd0; Lim_Hi = 5'd3; Step = 5'd5;
    #1;
    n_checks++;
    if (Cfg_Err !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_step: Cfg_Err=%b expected 1", Cfg_Err);
    end
    tick();
    n_checks++;
    if (Counter !== 5'd7 || Sat_Pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_step_frozen: Counter=%0d sat=%b expected 7/0", Counter, Sat_Pulse);
    end
    Up = 0;
  endtask

  task automatic test_single_window();
    Lim_Lo = 5'd5; Lim_Hi = 5'd5; Step = 5'd1; Mode = 1;
    tick();
    n_checks++;
    if (Counter !== 5'd5 || Sat_Pulse !== 1'b1 || High !== 1'b1 || Low !== 1'b1) begin
      n_fail++;
      $display("FAIL single_pull_in: Counter=%0d sat=%b H=%b L=%b expected 5/1/1/1", Counter, Sat_Pulse, High, Low);
    end
    Down = 1;
    tick();
    Down = 0;
    n_checks++;
    if (Counter !== 5'd5 || Wrap_Pulse !== 1'b1 || Sat_Pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL single_down: Counter=%0d wrap=%b sat=%b expected 5/1/0", Counter, Wrap_Pulse, Sat_Pulse);
    end
    Up = 1;
    tick();
    n_checks++;
    if (Counter !== 5'd5 || Wrap_Pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL single_up: Counter=%0d wrap=%b expected 5/1", Counter, Wrap_Pulse);
    end
    Step = 5'd0;
    tick();
    Up = 0;
    n_checks++;
    if (Counter !== 5'd5 || Wrap_Pulse !== 1'b0 || Sat_Pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL step_zero: Counter=%0d wrap=%b sat=%b expected 5/0/0", Counter, Wrap_Pulse, Sat_Pulse);
    end
  endtask

  task automatic test_both_and_reset();
    Lim_Lo = 5'd0; Lim_Hi = 5'd31; Step = 5'd2; Mode = 0;
    IN = 5'd15; Load = 1;
    tick();
    Load = 0; Up = 1; Down = 1;
    tick();
    Up = 0; Down = 0;
    n_checks++;
    if (Counter !== 5'd13) begin
      n_fail++;
      $display("FAIL up_and_down: Counter=%0d expected 13", Counter);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (Counter !== 5'd0 || Wrap_Pulse !== 1'b0 || Sat_Pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: Counter=%0d wrap=%b sat=%b expected 0/0/0", Counter, Wrap_Pulse, Sat_Pulse);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_up_saturate();
    test_wrap();
    test_down_saturate();
    test_load_clamp();
    test_cfg_err();
    test_single_window();
    test_both_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
